// File: rtl/f5_pkg.sv
// rtl/f5_pkg.sv - shared constants and state encoding for the F5 buffer sequencer
package f5_pkg;

    localparam int F5_DEPTH  = 25;
    localparam int F5_CH     = 16;
    localparam int F5_TOTAL  = F5_DEPTH * F5_CH;
    localparam int F5_RD_LAT = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_FULL  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FLUSH = 3'd4
    } f5_state_e;

endpackage

// File: rtl/f5_rd_tag_pipe.sv
// rtl/f5_rd_tag_pipe.sv - delay line carrying (valid, idx, last) alongside the RAM read latency
module f5_rd_tag_pipe #(
    parameter int IW    = 9,
    parameter int DEPTH = 3
) (
    input  logic          clk_i,
    input  logic          clr_i,
    input  logic          valid_i,
    input  logic [IW-1:0] idx_i,
    input  logic          last_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o,
    output logic          last_o
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] last_q;
    logic [IW-1:0]    idx_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            valid_q <= '0;
            last_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            last_q[0]  <= last_i;
            idx_q[0]   <= idx_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                last_q[i]  <= last_q[i-1];
                idx_q[i]   <= idx_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign last_o  = last_q[DEPTH-1];
    assign idx_o   = idx_q[DEPTH-1];

endmodule

// File: rtl/f5_ctrl.sv
// rtl/f5_ctrl.sv - F5 feature buffer sequencer: word fill, then flattened serial drain to F6
module f5_ctrl
    import f5_pkg::*;
#(
    parameter int DEPTH  = F5_DEPTH,
    parameter int CH     = F5_CH,
    parameter int AW     = 5,
    parameter int SW     = 4,
    parameter int IW     = 9,
    parameter int RD_LAT = F5_RD_LAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s4_valid,
    output logic          s4_ready,
    output logic          f5_wr_en,
    output logic [AW-1:0] f5_waddr,
    input  logic          f6_start,
    output logic [SW-1:0] f5_sel,
    output logic [AW-1:0] f5_raddr,
    output logic          f6_valid,
    output logic [IW-1:0] f6_idx,
    output logic          f6_last,
    output logic          frame_full,
    output logic          busy,
    output logic          ovf_err
);

    localparam int TOTAL = DEPTH * CH;
    localparam int FW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    f5_state_e      state_q;
    logic [AW-1:0]  waddr_q;
    logic [AW-1:0]  raddr_q;
    logic [IW-1:0]  c_q;
    logic [FW-1:0]  flush_q;
    logic           pending_q;
    logic           full_q;
    logic           ovf_q;

    logic           wr_fire;
    logic           draining;
    logic           last_issue;
    logic           last_word;

    assign s4_ready   = (state_q == ST_IDLE) || (state_q == ST_FILL);
    assign wr_fire    = s4_valid && s4_ready;
    assign draining   = (state_q == ST_DRAIN);
    assign last_issue = draining && (c_q == IW'(TOTAL - 1));
    assign last_word  = (waddr_q == AW'(DEPTH - 1));

    assign f5_wr_en   = wr_fire;
    assign f5_waddr   = waddr_q;
    assign f5_sel     = draining ? c_q[SW-1:0] : '0;
    assign f5_raddr   = raddr_q;
    assign frame_full = full_q;
    assign busy       = (state_q != ST_IDLE);
    assign ovf_err    = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            waddr_q   <= '0;
            raddr_q   <= '0;
            c_q       <= '0;
            flush_q   <= '0;
            pending_q <= 1'b0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (s4_valid && !s4_ready) begin
                ovf_q <= 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (f6_start) begin
                        pending_q <= 1'b1;
                    end
                    if (wr_fire) begin
                        waddr_q <= waddr_q + 1'b1;
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (f6_start) begin
                        pending_q <= 1'b1;
                    end
                    if (wr_fire) begin
                        if (last_word) begin
                            waddr_q <= '0;
                            full_q  <= 1'b1;
                            // A start seen at any point during the fill skips the FULL wait
                            if (pending_q || f6_start) begin
                                pending_q <= 1'b0;
                                c_q       <= '0;
                                state_q   <= ST_DRAIN;
                            end else begin
                                state_q <= ST_FULL;
                            end
                        end else begin
                            waddr_q <= waddr_q + 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    if (f6_start) begin
                        c_q     <= '0;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // RAM samples the address one cycle after the channel select
                    raddr_q <= AW'(c_q[IW-1:SW]);
                    if (last_issue) begin
                        full_q  <= 1'b0;
                        flush_q <= '0;
                        state_q <= ST_FLUSH;
                    end else begin
                        c_q <= c_q + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_q == FW'(RD_LAT - 1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        flush_q <= flush_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    f5_rd_tag_pipe #(
        .IW    (IW),
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk_i   (clk),
        .clr_i   (rst),
        .valid_i (draining),
        .idx_i   (draining ? c_q : '0),
        .last_i  (last_issue),
        .valid_o (f6_valid),
        .idx_o   (f6_idx),
        .last_o  (f6_last)
    );

endmodule

// File: tb/tb_f5_ctrl.sv
// tb/tb_f5_ctrl.sv - randomized self-checking bench for f5_ctrl with a behavioural RAM and stream model
module tb_f5_ctrl;

    logic        clk;
    logic        rst;
    logic        s4_valid;
    logic        s4_ready;
    logic        f5_wr_en;
    logic [4:0]  f5_waddr;
    logic        f6_start;
    logic [3:0]  f5_sel;
    logic [4:0]  f5_raddr;
    logic        f6_valid;
    logic [8:0]  f6_idx;
    logic        f6_last;
    logic        frame_full;
    logic        busy;
    logic        ovf_err;

    logic [15:0] mem [512];
    logic [15:0] wdata [16];
    logic [3:0]  sel_s1;
    logic [15:0] rd1;
    logic [15:0] f5_rdata;

    int n_checks = 0;
    int n_errors = 0;
    bit in_drain = 0;
    bit mon_en   = 0;
    bit exp_ovf  = 0;

    f5_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .s4_valid   (s4_valid),
        .s4_ready   (s4_ready),
        .f5_wr_en   (f5_wr_en),
        .f5_waddr   (f5_waddr),
        .f6_start   (f6_start),
        .f5_sel     (f5_sel),
        .f5_raddr   (f5_raddr),
        .f6_valid   (f6_valid),
        .f6_idx     (f6_idx),
        .f6_last    (f6_last),
        .frame_full (frame_full),
        .busy       (busy),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: sel sampled at t, raddr at t+1, data out at t+3
    always @(posedge clk) begin
        if (f5_wr_en) begin
            for (int j = 0; j < 16; j++) begin
                mem[{f5_waddr, 4'(j)}] <= wdata[j];
            end
        end
        sel_s1   <= f5_sel;
        rd1      <= mem[{f5_raddr, sel_s1}];
        f5_rdata <= rd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !in_drain) begin
            check("idle_no_valid", 32'(f6_valid), 32'd0);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            s4_valid = 1'b0;
            f6_start = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill(input int first_gap, input int gap_max, input int start_at, input logic [15:0] base);
        for (int k = 0; k < 25; k++) begin
            int gap;
            gap = (k == 0) ? first_gap : int'($urandom_range(0, gap_max));
            for (int g = 0; g < gap; g++) begin
                s4_valid = 1'b0;
                f6_start = 1'b0;
                @(posedge clk);
                #1;
            end
            s4_valid = 1'b1;
            f6_start = (k == start_at);
            for (int j = 0; j < 16; j++) begin
                wdata[j] = base + 16'(k * 16 + j);
            end
            @(negedge clk);
            check("wr_ready", 32'(s4_ready), 32'd1);
            check("wr_en", 32'(f5_wr_en), 32'd1);
            check("waddr", 32'(f5_waddr), 32'(k));
            if (k == 0) begin
                check("fill_from_idle", 32'(busy), 32'd0);
                check("fill_ovf", 32'(ovf_err), 32'(exp_ovf));
            end
            @(posedge clk);
            #1;
            s4_valid = 1'b0;
            f6_start = 1'b0;
        end
    endtask

    task automatic full_wait(input int cycles, input bit spam);
        for (int i = 0; i < cycles; i++) begin
            s4_valid = spam ? 1'($urandom % 2) : 1'b0;
            @(negedge clk);
            check("full_flag", 32'(frame_full), 32'd1);
            check("full_ready", 32'(s4_ready), 32'd0);
            check("full_busy", 32'(busy), 32'd1);
            check("full_no_wr", 32'(f5_wr_en), 32'd0);
            check("full_ovf", 32'(ovf_err), 32'(exp_ovf));
            if (s4_valid) exp_ovf = 1'b1;
            @(posedge clk);
            #1;
        end
        s4_valid = 1'b0;
        f6_start = 1'b1;
        @(negedge clk);
        check("start_in_full", 32'(frame_full), 32'd1);
        @(posedge clk);
        #1;
        f6_start = 1'b0;
    endtask

    // Called in the first DRAIN cycle (d=0); returns in the cycle after the last FLUSH cycle
    task automatic drain(input logic [15:0] base, input bit spam, input bit probe, input int abort_at);
        logic [15:0] exp16;
        int          ra;
        in_drain = 1'b1;
        for (int d = 0; d < 403; d++) begin
            if (spam) begin
                s4_valid = 1'($urandom % 2);
                f6_start = (d < 402) ? 1'($urandom % 4 == 0) : 1'b0;
            end
            if (probe && d == 402) s4_valid = 1'b1;
            if (d == abort_at) rst = 1'b1;
            @(negedge clk);
            check("drain_sel", 32'(f5_sel), 32'((d < 400) ? d % 16 : 0));
            check("drain_full", 32'(frame_full), 32'(d < 400));
            check("drain_busy", 32'(busy), 32'd1);
            check("drain_no_wr", 32'(f5_wr_en), 32'd0);
            check("drain_ready", 32'(s4_ready), 32'd0);
            check("drain_ovf", 32'(ovf_err), 32'(exp_ovf));
            if (d >= 1) begin
                ra = ((d - 1) < 399 ? (d - 1) : 399) / 16;
                check("drain_raddr", 32'(f5_raddr), 32'(ra));
            end
            check("f6_valid", 32'(f6_valid), 32'(d >= 3));
            if (d >= 3) begin
                exp16 = base + 16'(d - 3);
                check("f6_idx", 32'(f6_idx), 32'(d - 3));
                check("f6_rdata", 32'(f5_rdata), 32'(exp16));
                check("f6_last", 32'(f6_last), 32'(d - 3 == 399));
            end
            if (s4_valid) exp_ovf = 1'b1;
            @(posedge clk);
            #1;
            if (d == abort_at) begin
                rst      = 1'b0;
                s4_valid = 1'b0;
                f6_start = 1'b0;
                exp_ovf  = 1'b0;
                @(negedge clk);
                check("rst_valid", 32'(f6_valid), 32'd0);
                check("rst_idx", 32'(f6_idx), 32'd0);
                check("rst_last", 32'(f6_last), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_sel", 32'(f5_sel), 32'd0);
                check("rst_raddr", 32'(f5_raddr), 32'd0);
                check("rst_waddr", 32'(f5_waddr), 32'd0);
                check("rst_full", 32'(frame_full), 32'd0);
                check("rst_ovf", 32'(ovf_err), 32'd0);
                check("rst_ready", 32'(s4_ready), 32'd1);
                @(posedge clk);
                #1;
                break;
            end
        end
        s4_valid = 1'b0;
        f6_start = 1'b0;
        in_drain = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        s4_valid = 1'b0;
        f6_start = 1'b0;
        for (int j = 0; j < 16; j++) wdata[j] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(s4_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(f6_valid), 32'd0);
        check("reset_full", 32'(frame_full), 32'd0);
        check("reset_ovf", 32'(ovf_err), 32'd0);
        check("reset_sel", 32'(f5_sel), 32'd0);
        check("reset_raddr", 32'(f5_raddr), 32'd0);
        check("reset_waddr", 32'(f5_waddr), 32'd0);
        check("reset_wr_en", 32'(f5_wr_en), 32'd0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        fill(0, 0, -1, 16'h0000);
        full_wait(3, 1'b0);
        drain(16'h0000, 1'b0, 1'b0, -1);

        fill(1, 2, 10, 16'h1000);
        drain(16'h1000, 1'b1, 1'b0, -1);
        idle(4);
        @(negedge clk);
        check("ovf_sticky", 32'(ovf_err), 32'(exp_ovf));
        @(posedge clk);
        #1;

        fill(0, 1, -1, 16'h2000);
        full_wait(2, 1'b1);
        drain(16'h2000, 1'b0, 1'b0, 200);
        idle(8);

        begin
            bit prev_probe = 1'b0;
            for (int r = 0; r < 4; r++) begin
                logic [15:0] base;
                int          start_at;
                bit          probe;
                base     = 16'($urandom);
                start_at = ($urandom % 2) ? int'($urandom_range(0, 24)) : -1;
                probe    = (r < 3);
                fill(prev_probe ? 0 : int'($urandom_range(0, 3)), 2, start_at, base);
                if (start_at < 0) full_wait(int'($urandom_range(0, 4)), 1'($urandom % 2));
                drain(base, 1'($urandom % 2), probe, -1);
                prev_probe = probe;
            end
        end

        idle(5);
        @(negedge clk);
        check("final_busy", 32'(busy), 32'd0);
        check("final_ovf", 32'(ovf_err), 32'(exp_ovf));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
